// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and counter sizing for the restoring divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ZERO = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int CNT_W = $clog2(DEF_WIDTH);
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift in a bit, trial subtract).
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_o
);
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;
  always_comb begin
    r_sh = {r_i[WIDTH-1:0], bit_i};
    diff = r_sh - {1'b0, divisor_i};
    // a set top bit means the shifted value overflowed WIDTH+1 bits, so it exceeds any divisor
    q_o  = r_i[WIDTH] | (r_sh >= {1'b0, divisor_i});
    r_o  = q_o ? diff : r_sh;
  end
endmodule

// File: rtl/restoring_div8.sv
// restoring_div8: sequential unsigned radix-2 restoring divider, one quotient bit per clock.
module restoring_div8
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : $clog2(WIDTH);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, quot_q, quot_d, rem_q, rem_d;
  logic [WIDTH:0] r_q, r_d, step_r;
  logic step_q, busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i      (r_q),
    .bit_i    (dvd_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .r_o      (step_r),
    .q_o      (step_q)
  );
  // dividend register doubles as the quotient accumulator: bits leave the top, q bits enter the bottom
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        dvd_d   = dividend;
        dvs_d   = divisor;
        cnt_d   = '0;
        r_d     = '0;
        busy_d  = 1'b1;
        state_d = (divisor == '0) ? ZERO : RUN;
      end
      RUN: begin
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        r_d   = step_r;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quot_d  = dvd_d;
          rem_d   = step_r[WIDTH-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      ZERO: begin
        quot_d  = '1;
        rem_d   = dvd_q;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
